// File: rtl/bw_clk_cken_seq.sv
// Staggered per-region clock-enable sequencer for the gclk tree.
// Regions turn on ascending and off descending, with a gap between steps.
module bw_clk_cken_seq #(
    parameter int NREG  = 8,
    parameter int GAP_W = 4
) (
    input  logic             gclk,
    input  logic             arst_l,
    input  logic             en_req,
    input  logic [NREG-1:0]  region_mask,
    input  logic [GAP_W-1:0] gap,
    output logic [NREG-1:0]  cken,
    output logic             busy,
    output logic             all_on,
    output logic             all_off
);

    localparam int IW = $clog2(NREG);
    localparam logic [IW-1:0] LAST = IW'(NREG - 1);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [NREG-1:0]  mask_q, mask_d;
    logic [NREG-1:0]  cken_q, cken_d;

    logic step;
    logic hit;
    logic first;
    logic last;

    assign step  = (cnt_q == '0);
    assign hit   = mask_q[idx_q];
    assign first = (idx_q == '0);
    assign last  = (idx_q == LAST);

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q <= OFF;
            idx_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            mask_q  <= '0;
            cken_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            mask_q  <= mask_d;
            cken_q  <= cken_d;
        end
    end

    // A change of en_req always wins over a pending step or gap count.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        mask_d  = mask_q;
        cken_d  = cken_q;
        unique case (state_q)
            OFF: begin
                if (en_req) begin
                    mask_d  = region_mask;
                    gap_d   = gap;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = UP;
                end
            end
            UP: begin
                if (!en_req) begin
                    if (first) begin
                        state_d = OFF;
                    end else begin
                        state_d = DOWN;
                        idx_d   = idx_q - IW'(1);
                        cnt_d   = '0;
                    end
                end else if (!step) begin
                    cnt_d = cnt_q - GAP_W'(1);
                end else begin
                    if (hit) begin
                        cken_d[idx_q] = 1'b1;
                        cnt_d         = gap_q;
                    end
                    if (last) begin
                        state_d = ON;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ON: begin
                if (!en_req) begin
                    idx_d   = LAST;
                    cnt_d   = '0;
                    state_d = DOWN;
                end
            end
            DOWN: begin
                if (en_req) begin
                    if (last) begin
                        state_d = ON;
                    end else begin
                        state_d = UP;
                        idx_d   = idx_q + IW'(1);
                        cnt_d   = '0;
                    end
                end else if (!step) begin
                    cnt_d = cnt_q - GAP_W'(1);
                end else begin
                    if (hit) begin
                        cken_d[idx_q] = 1'b0;
                        cnt_d         = gap_q;
                    end
                    if (first) begin
                        state_d = OFF;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    assign cken    = cken_q;
    assign busy    = (state_q == UP) || (state_q == DOWN);
    assign all_on  = (state_q == ON);
    assign all_off = (state_q == OFF);

    a_status_onehot: assert property (
        @(posedge gclk) disable iff (!arst_l)
        $onehot({busy, all_on, all_off})
    );

    a_unmasked_off: assert property (
        @(posedge gclk) disable iff (!arst_l)
        (cken_q & ~mask_q) == '0
    );

endmodule

// File: tb/tb_bw_clk_cken_seq.sv
// Bench for bw_clk_cken_seq: vector table, corner sequences,
// and random traffic against a region-count reference model.
module tb_bw_clk_cken_seq;

    localparam int NREG  = 8;
    localparam int GAP_W = 4;

    logic             gclk = 1'b0;
    logic             arst_l;
    logic             en_req;
    logic [NREG-1:0]  region_mask;
    logic [GAP_W-1:0] gap;
    logic [NREG-1:0]  cken;
    logic             busy;
    logic             all_on;
    logic             all_off;

    int total = 0;
    int bad   = 0;

    always #5 gclk = ~gclk;

    bw_clk_cken_seq #(.NREG(NREG), .GAP_W(GAP_W)) dut (
        .gclk        (gclk),
        .arst_l      (arst_l),
        .en_req      (en_req),
        .region_mask (region_mask),
        .gap         (gap),
        .cken        (cken),
        .busy        (busy),
        .all_on      (all_on),
        .all_off     (all_off)
    );

    typedef struct {
        logic       en;
        logic [7:0] mask;
        logic [3:0] gap;
        logic [7:0] cken;
        logic [2:0] st;
    } vec_t;

    vec_t vt[26];

    localparam logic [2:0] S_BUSY = 3'b100;
    localparam logic [2:0] S_ON   = 3'b010;
    localparam logic [2:0] S_OFF  = 3'b001;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic e, input logic [7:0] m,
                        input logic [3:0] g, input logic [7:0] c,
                        input logic [2:0] s);
        vt[i].en   = e;
        vt[i].mask = m;
        vt[i].gap  = g;
        vt[i].cken = c;
        vt[i].st   = s;
    endtask

    task automatic do_reset();
        arst_l      = 1'b0;
        en_req      = 1'b0;
        region_mask = '0;
        gap         = '0;
        @(posedge gclk);
        #1;
        arst_l = 1'b1;
    endtask

    // Reference model: pos = number of regions currently processed,
    // ph = 0 off, 1 rising, 2 on, 3 falling; wt = idle cycles left.
    int         ph;
    int         pos;
    int         wt;
    logic [7:0] mm;
    int         gm;

    task automatic model_reset();
        ph  = 0;
        pos = 0;
        wt  = 0;
        mm  = '0;
        gm  = 0;
    endtask

    task automatic model_step(input logic e, input logic [7:0] m,
                              input logic [3:0] g);
        int r;
        case (ph)
            0: if (e) begin
                ph  = 1;
                pos = 0;
                wt  = 0;
                mm  = m;
                gm  = int'(g);
            end
            1: if (!e) begin
                if (pos == 0) ph = 0;
                else begin
                    ph = 3;
                    wt = 0;
                end
            end else if (wt > 0) begin
                wt--;
            end else begin
                r   = pos;
                pos = pos + 1;
                wt  = mm[r] ? gm : 0;
                if (pos == NREG) ph = 2;
            end
            2: if (!e) begin
                ph = 3;
                wt = 0;
            end
            default: if (e) begin
                if (pos == NREG) ph = 2;
                else begin
                    ph = 1;
                    wt = 0;
                end
            end else if (wt > 0) begin
                wt--;
            end else begin
                pos = pos - 1;
                r   = pos;
                wt  = mm[r] ? gm : 0;
                if (pos == 0) ph = 0;
            end
        endcase
    endtask

    function automatic logic [7:0] model_cken();
        logic [8:0] lo;
        lo = (9'd1 << pos) - 9'd1;
        return mm & lo[7:0];
    endfunction

    function automatic logic [2:0] model_st();
        if (ph == 0) return S_OFF;
        if (ph == 2) return S_ON;
        return S_BUSY;
    endfunction

    initial begin
        logic [7:0] e;
        logic [7:0] orv;
        int         n;

        // mask 05, gap 1: skips, gaps, both reversals, back to OFF
        setv(0,  1, 8'h05, 4'd1, 8'h00, S_BUSY);
        setv(1,  1, 8'h05, 4'd1, 8'h01, S_BUSY);
        setv(2,  1, 8'h05, 4'd1, 8'h01, S_BUSY);
        setv(3,  1, 8'h05, 4'd1, 8'h01, S_BUSY);
        setv(4,  1, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(5,  1, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(6,  1, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(7,  1, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(8,  1, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(9,  1, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(10, 1, 8'hFF, 4'hF, 8'h05, S_ON);
        setv(11, 1, 8'hFF, 4'hF, 8'h05, S_ON);
        setv(12, 0, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(13, 0, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(14, 0, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(15, 0, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(16, 0, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(17, 0, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(18, 0, 8'hFF, 4'hF, 8'h01, S_BUSY);
        setv(19, 1, 8'hFF, 4'hF, 8'h01, S_BUSY);
        setv(20, 1, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(21, 0, 8'hFF, 4'hF, 8'h05, S_BUSY);
        setv(22, 0, 8'hFF, 4'hF, 8'h01, S_BUSY);
        setv(23, 0, 8'hFF, 4'hF, 8'h01, S_BUSY);
        setv(24, 0, 8'hFF, 4'hF, 8'h01, S_BUSY);
        setv(25, 0, 8'hFF, 4'hF, 8'h00, S_OFF);

        // reset held with en_req=1
        arst_l      = 1'b0;
        en_req      = 1'b1;
        region_mask = 8'hFF;
        gap         = 4'd0;
        repeat (2) @(posedge gclk);
        #1;
        chk("rst_cken", cken, 8'h00);
        chk("rst_st", {busy, all_on, all_off}, S_OFF);
        arst_l = 1'b1;
        @(posedge gclk);
        #1;
        chk("rel_e0_cken", cken, 8'h00);
        chk("rel_e0_st", {busy, all_on, all_off}, S_BUSY);
        @(posedge gclk);
        #1;
        chk("rel_e1_cken", cken, 8'h01);

        // vector table
        do_reset();
        for (int i = 0; i < 26; i++) begin
            en_req      = vt[i].en;
            region_mask = vt[i].mask;
            gap         = vt[i].gap;
            @(posedge gclk);
            #1;
            chk($sformatf("vec%0d_cken", i), cken, vt[i].cken);
            chk($sformatf("vec%0d_st", i), {busy, all_on, all_off}, vt[i].st);
        end

        // full ramp, gap 3: 4-cycle spacing up then down
        do_reset();
        en_req      = 1'b1;
        region_mask = 8'hFF;
        gap         = 4'd3;
        for (int k = 0; k < 30; k++) begin
            @(posedge gclk);
            #1;
            e = '0;
            for (int i = 0; i < 8; i++) if (1 + 4 * i <= k) e[i] = 1'b1;
            chk($sformatf("up%0d_cken", k), cken, e);
            chk($sformatf("up%0d_st", k), {busy, all_on, all_off},
                (k >= 29) ? S_ON : S_BUSY);
        end
        en_req = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge gclk);
            #1;
            e = 8'hFF;
            for (int i = 0; i < 8; i++) if (1 + 4 * (7 - i) <= k) e[i] = 1'b0;
            chk($sformatf("dn%0d_cken", k), cken, e);
            chk($sformatf("dn%0d_st", k), {busy, all_on, all_off},
                (k >= 29) ? S_OFF : S_BUSY);
        end

        // sparse mask A5, gap 2
        do_reset();
        en_req      = 1'b1;
        region_mask = 8'hA5;
        gap         = 4'd2;
        orv         = '0;
        n           = 0;
        while (n < 40) begin
            @(posedge gclk);
            #1;
            n++;
            orv |= cken;
            if (all_on) break;
        end
        chk("sparse_edges", n, 15);
        chk("sparse_or", orv, 8'hA5);
        chk("sparse_on_cken", cken, 8'hA5);

        // async reset mid-UP
        do_reset();
        en_req      = 1'b1;
        region_mask = 8'hFF;
        gap         = 4'd0;
        repeat (4) @(posedge gclk);
        #1;
        chk("mid_up_cken", cken, 8'h07);
        #2;
        arst_l = 1'b0;
        #1;
        chk("async_cken", cken, 8'h00);
        chk("async_st", {busy, all_on, all_off}, S_OFF);
        #3;
        arst_l = 1'b1;
        en_req = 1'b0;

        // random traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 29) == 0) en_req = ~en_req;
            region_mask = 8'($urandom);
            gap         = 4'($urandom_range(0, 3));
            @(posedge gclk);
            model_step(en_req, region_mask, gap);
            #1;
            chk($sformatf("rnd%0d_cken", c), cken, model_cken());
            chk($sformatf("rnd%0d_st", c), {busy, all_on, all_off}, model_st());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
